// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM datapath widths and feeder state encoding
package pwm_pkg;

  localparam int DEF_DATA_WIDTH    = 12;
  localparam int DEF_COUNTER_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feeder_state_t;

  // A level counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - power-of-two synchronous sample FIFO with level and flush
module sample_fifo
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [LW-1:0]         o_level
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // The caller never pushes when full nor pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!i_push && i_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/pwm_feeder.sv
// rtl/pwm_feeder.sv - releases one buffered sample per PWM frame, with priming and underrun silence
module pwm_feeder
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] pwm_data,
  output logic                  frame_tick,
  output logic [15:0]           underrun_cnt,
  output logic                  playing
);

  localparam int            LW        = level_width(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  feeder_state_t           r_state;
  feeder_state_t           w_state_next;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [COUNTER_WIDTH-1:0] w_cnt_next;
  logic                    r_frame_tick;
  logic                    r_playing;
  logic [DATA_WIDTH-1:0]   r_pwm_data;
  logic [15:0]             r_underrun_cnt;
  logic [DATA_WIDTH-1:0]   w_head;
  logic [LW-1:0]           w_level;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_underrun;
  logic                    w_flush;

  // The tick register looks one count ahead so it is high while the counter is all-ones.
  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_frame_tick <= &w_cnt_next;
    end
  end

  assign s_ready = (r_state != IDLE) && (w_level < FULL_LVL);
  assign w_push  = s_valid && s_ready;
  assign w_flush = !enable;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_underrun   = 1'b0;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = PRIME;
        PRIME: begin
          if (r_frame_tick && (w_level >= PRIME_LVL)) begin
            w_pop        = 1'b1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (r_frame_tick) begin
            if (w_level != '0) begin
              w_pop = 1'b1;
            end else begin
              w_underrun   = 1'b1;
              w_state_next = PRIME;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_playing      <= 1'b0;
      r_pwm_data     <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_playing <= (w_state_next == RUN);
      if (!enable || w_underrun) begin
        r_pwm_data <= '0;
      end else if (w_pop) begin
        r_pwm_data <= w_head;
      end
      if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data (s_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level)
  );

  assign pwm_data     = r_pwm_data;
  assign frame_tick   = r_frame_tick;
  assign underrun_cnt = r_underrun_cnt;
  assign playing      = r_playing;

endmodule

// File: doc/pwm_feeder.md
# pwm_feeder

Sample scheduler in front of the PWM output stage. Accepts signed 12-bit audio samples from the demodulator over a valid/ready stream, buffers them in a small FIFO, and releases exactly one sample per PWM frame on a frame-aligned strobe. Handles start-up priming, underrun (forces mid-scale silence) and enable/disable. Its `pwm_data` output drives the PWM `DataIn`.

## Interface
- `DATA_WIDTH`, 12, sample width (two's complement)
- `COUNTER_WIDTH`, 10, frame length exponent; frame = 2^COUNTER_WIDTH clk cycles, same value as the PWM stage
- `FIFO_DEPTH`, 4, sample buffer entries (power of two, ≥2)
- `PRIME_LEVEL`, 2, FIFO fill required before playback starts (1..FIFO_DEPTH)

- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `enable`  in  1  playback enable, level-sensitive
- `s_valid`  in  1  input sample valid
- `s_data`  in  DATA_WIDTH  input sample
- `s_ready`  out  1  feeder can accept a sample this cycle
- `pwm_data`  out  DATA_WIDTH  sample presented to PWM, stable for a whole frame
- `frame_tick`  out  1  one-cycle strobe, last cycle of each frame
- `underrun_cnt`  out  16  saturating underrun event count
- `playing`  out  1  high while in RUN

## Operation
- Frame counter: COUNTER_WIDTH bits, free-running, +1 every cycle, wraps. `frame_tick` = (counter == all-ones), registered so it is high in that cycle.
- Transfer: push when `s_valid && s_ready`. `s_ready` = (state != IDLE) && (level < FIFO_DEPTH), combinational from registered state/level. A full FIFO gives `s_ready`=0 even if a pop occurs in the same cycle.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: FIFO flushed, `pwm_data`=0 (0 is mid-scale, 50 % duty after the PWM offset). `enable`=1 → PRIME.
  - PRIME: accepts pushes. On a `frame_tick` with level ≥ PRIME_LEVEL → pop the head into `pwm_data` and go to RUN. `pwm_data` stays 0 until then.
  - RUN: on each `frame_tick`, if level > 0, pop into `pwm_data`. If level = 0 (underrun): `pwm_data` ← 0, `underrun_cnt` +1 (saturates at 0xFFFF), → PRIME.
  - Any state, `enable`=0 → IDLE on the next edge: FIFO level ← 0, `pwm_data` ← 0. `underrun_cnt` is kept.
- Same-cycle push and pop: both take effect and the level is unchanged. A pop sees only entries present before that edge, so a sample pushed in the `frame_tick` cycle cannot be popped in that same cycle.
- Samples pass through unmodified, with no sign handling. FIFO order is strict.

## Timing
- Reset values: counter 0, state IDLE, `pwm_data` 0, `frame_tick` 0, `underrun_cnt` 0, `playing` 0, `s_ready` 0, FIFO level 0.
- `pwm_data` changes only on the edge that ends a `frame_tick` cycle, or on the edge after `enable` falls.
- Latency, from first accepted sample to its appearance on `pwm_data`: the first `frame_tick` at which level ≥ PRIME_LEVEL, plus one edge. Maximum 2^COUNTER_WIDTH cycles after priming completes.
- `playing` is registered and equals (state == RUN).
- Reset asserted mid-frame clears everything asynchronously. After release, the counter restarts from 0, so the first `frame_tick` comes 2^COUNTER_WIDTH − 1 cycles later.

## Structure
- Shared package `pwm_pkg`: DATA_WIDTH and COUNTER_WIDTH defaults, shared by the PWM stage and the feeder, plus the `feeder_state_t` enum {IDLE, PRIME, RUN}.
- One sub-module, `sample_fifo`: synchronous FIFO with a power-of-two depth, level output and `flush` input. The top level holds the frame counter, FSM and counters.
- Expected size is about 200 lines of RTL total.

## Test plan
All scenarios use COUNTER_WIDTH=4 (16-cycle frame), FIFO_DEPTH=4, PRIME_LEVEL=2.

- Reset: hold `rst_n`=0 for 3 cycles, then release. Every output is 0; `frame_tick` first fires at cycle 15 after release and then every 16 cycles.
- Priming and order: set `enable`=1 and push 0x123, 0xF00, 0x7FF back-to-back. At the first tick with level ≥ 2, `pwm_data`=0x123 and `playing`=1. The next two ticks give 0xF00 then 0x7FF.
- Full FIFO: hold `s_valid`=1 without ticks. Exactly 4 samples are accepted, then `s_ready`=0. After a tick pops one, `s_ready` returns to 1 and exactly one more push is accepted.
- Underrun: in RUN, feed no samples past the last pop. At the next tick, `pwm_data`=0, `underrun_cnt`=1 and `playing`=0. Push 2 more samples; playback resumes on the following tick.
- Disable mid-frame: in RUN with 3 samples queued, drop `enable` at cycle 7 of the frame. On the next edge, `pwm_data`=0, `s_ready`=0 and the level is 0. Re-enable and check that no stale sample is ever output.
- Same-cycle push and pop: with level 2, push exactly in the `frame_tick` cycle. After the edge the level is 2, and `pwm_data` holds the old head, not the new sample.
